// File: rtl/multi_channel_sequencer.sv
// Plays NUM_CHANNELS order/pattern streams from one shared ROM, timing each note by
// counting enabled ticks, and emits notes one at a time tagged with their channel.
module multi_channel_sequencer #(
    parameter int  NUM_CHANNELS = 4,
    parameter int  ADDR_WIDTH   = 10,
    parameter int  ORDER_BASE   = 16,
    parameter int  PATTERN_BASE = 512,
    localparam int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_enable,
    input  logic                    i_tick,
    output logic                    o_note_valid,
    input  logic                    i_note_ready,
    output logic [CH_W-1:0]         o_note_channel,
    output logic [5:0]              o_note_pitch,
    output logic [4:0]              o_note_len,
    output logic [3:0]              o_note_instrument,
    output logic [NUM_CHANNELS-1:0] o_done,
    output logic                    o_busy,
    output logic [ADDR_WIDTH-1:0]   o_rom_addr,
    input  logic [15:0]             i_rom_data
);

    typedef enum logic [3:0] {
        IDLE, HDR_ADDR, HDR_READ, ARB, ORD_ADDR, ORD_READ, PAT_ADDR, PAT_READ, OUTPUT
    } state_t;

    state_t state, state_next;

    logic [CH_W-1:0] ch, rr_ptr, grant_ch, rr_next, cand;
    logic            grant_found, accept, tick_en;

    logic [5:0] order_idx [NUM_CHANNELS];
    logic [5:0] last_idx  [NUM_CHANNELS];
    logic [5:0] rep_idx   [NUM_CHANNELS];
    logic [7:0] ptr       [NUM_CHANNELS];
    logic [7:0] len       [NUM_CHANNELS];
    logic [7:0] count     [NUM_CHANNELS];
    logic [5:0] wait_cnt  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rep_en, need_order, pending, done;

    logic [5:0] note_pitch;
    logic [4:0] note_len;
    logic [3:0] note_instr;
    logic [5:0] note_wait;

    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_CHANNELS) sum = sum - NUM_CHANNELS;
        return CH_W'(sum);
    endfunction

    assign accept    = (state == OUTPUT) && i_note_ready;
    assign tick_en   = i_tick && i_enable;
    assign note_wait = (note_len == 5'd0) ? 6'd32 : {1'b0, note_len};

    // Round-robin: first live, pending channel at or after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cand = wrap_add(rr_ptr, i);
            if (!grant_found && pending[cand] && !done[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign rr_next = wrap_add(grant_ch, 1);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_rom_addr = '0;
        case (state)
            IDLE:     if (i_start) state_next = HDR_ADDR;
            HDR_ADDR: begin
                o_rom_addr = ADDR_WIDTH'(ch);
                state_next = HDR_READ;
            end
            HDR_READ: state_next = (int'(ch) < NUM_CHANNELS - 1) ? HDR_ADDR : ARB;
            ARB: begin
                if (&done)            state_next = IDLE;
                else if (grant_found) state_next = need_order[grant_ch] ? ORD_ADDR : PAT_ADDR;
            end
            ORD_ADDR: begin
                o_rom_addr = ADDR_WIDTH'(ORDER_BASE + int'(ch) * 64 + int'(order_idx[ch]));
                state_next = ORD_READ;
            end
            ORD_READ: state_next = PAT_ADDR;
            PAT_ADDR: begin
                o_rom_addr = ADDR_WIDTH'(PATTERN_BASE + int'(ptr[ch]));
                state_next = PAT_READ;
            end
            PAT_READ: state_next = OUTPUT;
            OUTPUT:   if (i_note_ready) state_next = ARB;
            default:  state_next = IDLE;
        endcase
    end

    // Tick countdown first; the OUTPUT reload below overrides it for the accepted channel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ch         <= '0;
            rr_ptr     <= '0;
            rep_en     <= '0;
            need_order <= '0;
            pending    <= '0;
            done       <= '0;
            note_pitch <= '0;
            note_len   <= '0;
            note_instr <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                order_idx[c] <= '0;
                last_idx[c]  <= '0;
                rep_idx[c]   <= '0;
                ptr[c]       <= '0;
                len[c]       <= '0;
                count[c]     <= '0;
                wait_cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (tick_en && !done[c] && wait_cnt[c] != 6'd0) begin
                    wait_cnt[c] <= wait_cnt[c] - 6'd1;
                    if (wait_cnt[c] == 6'd1) pending[c] <= 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        ch     <= '0;
                        rr_ptr <= '0;
                        done   <= '0;
                    end
                end
                HDR_READ: begin
                    last_idx[ch]   <= i_rom_data[5:0];
                    rep_idx[ch]    <= i_rom_data[11:6];
                    rep_en[ch]     <= i_rom_data[12];
                    order_idx[ch]  <= '0;
                    need_order[ch] <= 1'b1;
                    pending[ch]    <= 1'b1;
                    done[ch]       <= 1'b0;
                    wait_cnt[ch]   <= '0;
                    if (int'(ch) < NUM_CHANNELS - 1) ch <= ch + 1'b1;
                end
                ARB: begin
                    if (grant_found && !(&done)) begin
                        ch     <= grant_ch;
                        rr_ptr <= rr_next;
                    end
                end
                ORD_READ: begin
                    ptr[ch]        <= i_rom_data[7:0];
                    len[ch]        <= i_rom_data[15:8];
                    count[ch]      <= 8'd1;
                    need_order[ch] <= 1'b0;
                end
                PAT_READ: begin
                    note_pitch <= i_rom_data[5:0];
                    note_len   <= i_rom_data[10:6];
                    note_instr <= i_rom_data[14:11];
                end
                OUTPUT: begin
                    if (accept) begin
                        pending[ch]  <= 1'b0;
                        wait_cnt[ch] <= note_wait;
                        if (count[ch] < len[ch]) begin
                            ptr[ch]   <= ptr[ch] + 8'd1;
                            count[ch] <= count[ch] + 8'd1;
                        end else if (order_idx[ch] == last_idx[ch]) begin
                            if (rep_en[ch]) begin
                                order_idx[ch]  <= rep_idx[ch];
                                need_order[ch] <= 1'b1;
                            end else begin
                                done[ch] <= 1'b1;
                            end
                        end else begin
                            order_idx[ch]  <= order_idx[ch] + 6'd1;
                            need_order[ch] <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_note_valid      = (state == OUTPUT);
    assign o_note_channel    = ch;
    assign o_note_pitch      = note_pitch;
    assign o_note_len        = note_len;
    assign o_note_instrument = note_instr;
    assign o_done            = done;
    assign o_busy            = (state != IDLE);

endmodule

// File: tb/tb_multi_channel_sequencer.sv
// Bench for multi_channel_sequencer: per-channel note scoreboards filled by walking the
// ROM tables, checked by a monitor under randomized ready/tick/enable traffic.
module tb_multi_channel_sequencer;

    localparam int NCH          = 4;
    localparam int AW           = 10;
    localparam int ORDER_BASE   = 16;
    localparam int PATTERN_BASE = 512;
    localparam int CHW          = 2;

    typedef struct packed {
        logic [5:0] pitch;
        logic [4:0] len;
        logic [3:0] instr;
    } note_t;

    logic           clk = 1'b0;
    logic           rst, start, enable, tick, note_ready;
    logic           note_valid, busy;
    logic [CHW-1:0] note_channel;
    logic [5:0]     note_pitch;
    logic [4:0]     note_len;
    logic [3:0]     note_instr;
    logic [NCH-1:0] done_w;
    logic [AW-1:0]  rom_addr;
    logic [15:0]    rom_data;
    logic [15:0]    rom [1024];

    note_t exp_q [NCH][$];
    int    tick_cnt [NCH];
    int    need_gap [NCH];
    int    acc_cnt  [NCH];
    int    ch_seq [$];
    int    checks = 0;
    int    errors = 0;
    int    rdy_mode = 1;
    int    tick_pct = 100;
    int    en_pct = 100;
    int    stall_left = 0;
    bit    stalled = 1'b0;
    int    held_c, mon_c, acc_c;
    note_t exp_n;

    multi_channel_sequencer #(
        .NUM_CHANNELS(NCH), .ADDR_WIDTH(AW), .ORDER_BASE(ORDER_BASE), .PATTERN_BASE(PATTERN_BASE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_enable(enable), .i_tick(tick),
        .o_note_valid(note_valid), .i_note_ready(note_ready), .o_note_channel(note_channel),
        .o_note_pitch(note_pitch), .o_note_len(note_len), .o_note_instrument(note_instr),
        .o_done(done_w), .o_busy(busy), .o_rom_addr(rom_addr), .i_rom_data(rom_data)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Each channel's note list follows from the tables alone, independent of timing.
    function automatic void build_model();
        for (int c = 0; c < NCH; c++) begin
            logic [15:0] hdr, ord, pw;
            int    k, n_len;
            note_t n;
            hdr = rom[c];
            exp_q[c].delete();
            k = 0;
            while (exp_q[c].size() < 64) begin
                ord   = rom[ORDER_BASE + c * 64 + k];
                n_len = (ord[15:8] == 8'd0) ? 1 : int'(ord[15:8]);
                for (int i = 0; i < n_len; i++) begin
                    pw      = rom[PATTERN_BASE + ((int'(ord[7:0]) + i) % 256)];
                    n.pitch = pw[5:0];
                    n.len   = pw[10:6];
                    n.instr = pw[14:11];
                    exp_q[c].push_back(n);
                end
                if (k == int'(hdr[5:0])) begin
                    if (!hdr[12]) break;
                    k = int'(hdr[11:6]);
                end else begin
                    k++;
                end
            end
            tick_cnt[c] = 0;
            need_gap[c] = -1;
            acc_cnt[c]  = 0;
        end
        ch_seq.delete();
    endfunction

    task automatic applyStimulus();
        build_model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, int'(busy), 0);
    endtask

    task automatic wait_notes(input int c, input int target, input int max_cycles, input string name);
        int n = 0;
        while (acc_cnt[c] < target && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, int'(acc_cnt[c] >= target), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_valid"}, int'(note_valid), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done_w), 0);
        checkOutput({tag, "_rom_addr"}, int'(rom_addr), 0);
        checkOutput({tag, "_channel"}, int'(note_channel), 0);
        checkOutput({tag, "_note"}, int'({note_pitch, note_len, note_instr}), 0);
    endtask

    // Input driver: ticks, enable and ready change 1 time unit after each rising edge.
    initial begin
        tick       = 1'b0;
        enable     = 1'b1;
        note_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tick   = ($urandom_range(0, 99) < tick_pct);
            enable = ($urandom_range(0, 99) < en_pct);
            if (rdy_mode == 1) begin
                note_ready = 1'b1;
            end else if (stall_left > 0) begin
                note_ready = 1'b0;
                stall_left--;
            end else if (note_valid && $urandom_range(0, 7) == 0) begin
                note_ready = 1'b0;
                stall_left = 9;
            end else begin
                note_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: whatever is sampled here is what the next rising edge acts on.
    always @(negedge clk) begin
        acc_c = -1;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) checkOutput("stall_valid_held", int'(note_valid), 1);
            if (note_valid) begin
                mon_c = int'(note_channel);
                if (stalled) checkOutput("stall_channel_held", mon_c, held_c);
                if (exp_q[mon_c].size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_note: got ch%0d pitch %0d, expected no note", mon_c, note_pitch);
                end else begin
                    exp_n = exp_q[mon_c][0];
                    checkOutput($sformatf("ch%0d_pitch", mon_c), int'(note_pitch), int'(exp_n.pitch));
                    checkOutput($sformatf("ch%0d_len", mon_c), int'(note_len), int'(exp_n.len));
                    checkOutput($sformatf("ch%0d_instr", mon_c), int'(note_instr), int'(exp_n.instr));
                    if (!stalled && need_gap[mon_c] >= 0)
                        checkOutput($sformatf("ch%0d_enough_ticks(%0d of %0d)", mon_c, tick_cnt[mon_c], need_gap[mon_c]),
                                    int'(tick_cnt[mon_c] >= need_gap[mon_c]), 1);
                end
                if (note_ready) begin
                    if (exp_q[mon_c].size() != 0) begin
                        exp_n = exp_q[mon_c].pop_front();
                        need_gap[mon_c] = (exp_n.len == 5'd0) ? 32 : int'(exp_n.len);
                    end
                    acc_cnt[mon_c]++;
                    ch_seq.push_back(mon_c);
                    acc_c   = mon_c;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_c  = mon_c;
                end
            end else begin
                stalled = 1'b0;
            end
            if (tick && enable)
                for (int c = 0; c < NCH; c++) tick_cnt[c]++;
            if (acc_c >= 0) tick_cnt[acc_c] = 0;
        end
    end

    initial begin
        int lat;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        for (int a = 0; a < 1024; a++) rom[a] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Round robin: two one-note orders per channel, consumer always ready.
        for (int c = 0; c < NCH; c++) begin
            rom[c] = 16'h0001;
            for (int k = 0; k < 2; k++) begin
                rom[ORDER_BASE + c * 64 + k] = {8'd1, 8'(c * 8 + k)};
                rom[PATTERN_BASE + c * 8 + k] = {1'b0, 4'(c), 5'd1, 6'(c * 10 + k + 1)};
            end
        end
        rdy_mode = 1;
        tick_pct = 100;
        en_pct   = 100;
        applyStimulus();
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!note_valid && lat < 40);
        checkOutput("first_note_latency", lat, 2 * NCH + 5);
        wait_idle(2000, "rr_song_finished");
        checkOutput("rr_note_count", ch_seq.size(), 2 * NCH);
        for (int i = 0; i < ch_seq.size() && i < 2 * NCH; i++)
            checkOutput($sformatf("rr_order_%0d", i), ch_seq[i], i % NCH);
        checkOutput("rr_done_mask", int'(done_w), 15);

        // Random songs, random backpressure and pauses.
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < NCH; c++) begin
                logic [15:0] hdr;
                hdr       = 16'($urandom());
                hdr[12]   = 1'b0;
                hdr[5:0]  = 6'($urandom_range(0, 3));
                rom[c]    = hdr;
                for (int k = 0; k < 4; k++)
                    rom[ORDER_BASE + c * 64 + k] = {8'($urandom_range(0, 3)), 8'($urandom())};
            end
            for (int p = 0; p < 256; p++) rom[PATTERN_BASE + p] = 16'($urandom());
            rdy_mode = 0;
            tick_pct = 50;
            en_pct   = 80;
            applyStimulus();
            wait_idle(20000, $sformatf("random_song_%0d_finished", it));
            for (int c = 0; c < NCH; c++)
                checkOutput($sformatf("random_%0d_ch%0d_missing_notes", it, c), exp_q[c].size(), 0);
            checkOutput($sformatf("random_%0d_done_mask", it), int'(done_w), 15);
            repeat (5) @(posedge clk);
            #1;
            checkOutput($sformatf("random_%0d_done_held", it), int'(done_w), 15);
        end

        // Repeating channel 0 (orders 0,1 then 1 forever); others play one note.
        rom[0] = 16'h1041;
        rom[ORDER_BASE + 0] = {8'd1, 8'h10};
        rom[ORDER_BASE + 1] = {8'd1, 8'h20};
        for (int c = 1; c < NCH; c++) begin
            rom[c] = 16'h0000;
            rom[ORDER_BASE + c * 64] = {8'd1, 8'(8'h30 + c)};
        end
        for (int p = 0; p < 256; p++)
            rom[PATTERN_BASE + p] = {1'b0, 4'($urandom()), 5'($urandom_range(1, 3)), 6'($urandom())};
        rom[PATTERN_BASE + 8'h10] = {1'b0, 4'd3, 5'd2, 6'd10};
        rom[PATTERN_BASE + 8'h20] = {1'b0, 4'd5, 5'd1, 6'd20};
        tick_pct = 60;
        en_pct   = 90;
        applyStimulus();
        wait_notes(0, 6, 5000, "repeat_six_notes");
        checkOutput("repeat_done_mask", int'(done_w), 14);
        checkOutput("repeat_still_busy", int'(busy), 1);

        // Reset while the order word is being read, then replay from order 0.
        n = 0;
        while (!(rom_addr >= AW'(ORDER_BASE) && rom_addr < AW'(ORDER_BASE + 64)) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("found_order_fetch", int'(n < 2000), 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        rst = 1'b0;
        applyStimulus();
        wait_notes(0, 3, 3000, "replay_three_notes");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_sequencer.md
Name: multi_channel_sequencer

Overview:
- Multi-channel successor to the single-channel pattern sequencer. Plays NUM_CHANNELS independent order/pattern streams from one shared 16-bit ROM.
- Each channel times its own notes by counting i_tick strobes over the note length. There is no external per-note strobe.
- Notes are emitted one at a time on a single valid/ready output tagged with the channel index. Sits between the song ROM and the per-channel voice generators.

Parameters:
- NUM_CHANNELS, 4, channel count (1..8); CH_W = max(1, clog2(NUM_CHANNELS)).
- ADDR_WIDTH, 10, ROM address width.
- ORDER_BASE, 16, ROM address of channel 0's order table; must be >= NUM_CHANNELS.
- PATTERN_BASE, 512, ROM address added to every 8-bit pattern pointer.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  one-cycle pulse; begins header load from IDLE
- i_enable  in  1  when low, i_tick is ignored (pause)
- i_tick  in  1  note-time strobe
- o_note_valid  out  1  note available
- i_note_ready  in  1  consumer accepts note
- o_note_channel  out  CH_W  channel of the current note
- o_note_pitch  out  6  pitch
- o_note_len  out  5  length in ticks; 0 means 32
- o_note_instrument  out  4  instrument
- o_done  out  NUM_CHANNELS  per-channel stopped flag
- o_busy  out  1  high in every state except IDLE
- o_rom_addr  out  ADDR_WIDTH  combinational ROM address
- i_rom_data  in  16  ROM word, valid the cycle after the address

Behaviour:
- ROM protocol: o_rom_addr is driven in cycle N; i_rom_data is sampled in N+1. o_rom_addr = 0 in states that do no ROM access.
- Header for channel c at address c: [5:0] last order index, [11:6] repeat index, [12] repeat enable.
- Order entry for channel c, index k: address ORDER_BASE + c*64 + k. Word = {len[7:0], ptr[7:0]}.
- Pattern word: address PATTERN_BASE + ptr. [5:0] pitch, [10:6] length, [14:11] instrument.
- Pattern length: a length of L plays L notes; L = 0 is treated as 1.
- Per-channel state: order_idx, last_idx, rep_idx, rep_en, ptr, len, count, wait (6 bits), need_order, pending, done.
- FSM states: IDLE, HDR_ADDR, HDR_READ, ARB, ORD_ADDR, ORD_READ, PAT_ADDR, PAT_READ, OUTPUT.
  - IDLE: on i_start, go to HDR_ADDR with channel c = 0.
  - HDR_ADDR → HDR_READ: latch header fields; order_idx = 0, need_order = 1, pending = 1, done = 0, wait = 0. If c < NUM_CHANNELS-1, increment c and go to HDR_ADDR; otherwise go to ARB.
  - ARB: grant the lowest channel at or after rr_ptr (wrapping) with pending = 1 and done = 0. Set rr_ptr = grant + 1. Go to ORD_ADDR if need_order, else PAT_ADDR. With no candidate, stay in ARB.
  - ORD_READ: latch ptr and len; count = 1; need_order = 0.
  - PAT_READ: latch note fields and go to OUTPUT.
  - OUTPUT: o_note_valid = 1; all note outputs stay stable until i_note_ready. On the accepting cycle:
    - pending = 0; wait = note length (0 → 32).
    - If count < len: ptr += 1 (8-bit wrap) and count += 1.
    - Else, if order_idx == last_idx: when rep_en, order_idx = rep_idx and need_order = 1; otherwise done = 1.
    - Else: order_idx += 1 and need_order = 1.
    - Then return to ARB.
- Latency from grant: o_note_valid rises 4 cycles after ARB when an order fetch is needed, 2 cycles after ARB when it is not.
- Tick handling: on i_tick & i_enable, every non-done channel with wait > 0 decrements wait. A channel whose wait reaches 0 sets pending.
  - wait saturates at 0; lateness does not accumulate.
  - The load in OUTPUT takes priority over a same-cycle decrement for that channel.
- When all channels are done, return to IDLE at the next ARB. o_done holds its value until i_start or reset.
- i_start is ignored outside IDLE.
- Reset, including mid-operation, returns the FSM to IDLE and clears all channel state. All outputs reset to 0.

Test Plan:
- Single channel (NUM_CHANNELS=1): header 0x0000; order[0] = {len 2, ptr 0}; pattern[0] = 0x0105, pattern[1] = 0x0A0C; i_start.
  - Required: first note pitch 5, len 4, instr 0, with valid 4 cycles after ARB.
  - Second note (pitch 12, len 8, instr 1) valid only after 4 ticks.
  - After the second note, o_done = 1 and the block returns to IDLE.
- Repeat: header last = 1, rep = 1, en = 1; order entries 0 and 1 each with len 1.
  - Required note order: 0, 1, 1, 1, ...; never stops.
- Four channels, all lengths 1, i_note_ready always high: notes emitted with channel order 0, 1, 2, 3, 0, ...
- Backpressure: hold i_note_ready = 0 for 10 cycles during OUTPUT.
  - Required: outputs stable throughout; ticks continue decrementing other channels' waits; the note is accepted exactly once.
- i_enable = 0 for 5 ticks: wait counters frozen and no new notes issued.
- Reset pulse in ORD_READ: all outputs 0 and state IDLE the next cycle; a subsequent i_start replays the song from order index 0.
